// File: rtl/hazard_scoreboard.sv
// Producer-side hazard scoreboard: per-register cycles-until-forwardable plus long-unit occupancy.
// Optional stall-cycle counter enabled by defining HAZARD_STALL_PERF_EN.
module hazard_scoreboard #(
    parameter int LAT_W = 3,
    parameter int NREG  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             id_RegWrite,
    input  logic [4:0]       id_rd_addr,
    input  logic [LAT_W-1:0] id_lat,
    input  logic             id_long,
    input  logic             long_done,
    input  logic             flush,
    output logic             stall,
    output logic             PC_write,
    output logic             IFID_write,
    output logic             ID_bubble,
    output logic             long_busy,
    output logic [31:0]      stall_count
);

    typedef enum logic {L_IDLE, L_BUSY} lstate_t;

    localparam logic [LAT_W-1:0] LAT_ONE = LAT_W'(1);
    localparam logic [LAT_W-1:0] LAT_TWO = LAT_W'(2);

    lstate_t          lstate;
    logic [LAT_W-1:0] cnt [NREG];
    logic             rs1_haz;
    logic             rs2_haz;
    logic             raw_haz;
    logic             struct_haz;
    logic             issue;
    logic [LAT_W-1:0] eff_lat;

    // An entry still >= 2 means the producer cannot forward into EX next cycle.
    always_comb begin
        rs1_haz = id_uses_rs1 && (id_rs1_addr != 5'd0) && (cnt[id_rs1_addr] >= LAT_TWO);
        rs2_haz = id_uses_rs2 && (id_rs2_addr != 5'd0) && (cnt[id_rs2_addr] >= LAT_TWO);
    end

    assign raw_haz    = id_valid && (rs1_haz || rs2_haz);
    assign struct_haz = id_valid && id_long && (lstate == L_BUSY) && !long_done;
    assign stall      = (raw_haz || struct_haz) && !flush;
    assign PC_write   = !stall;
    assign IFID_write = !stall;
    assign ID_bubble  = stall || flush;
    assign issue      = id_valid && !stall && !flush;
    assign eff_lat    = (id_lat == '0) ? LAT_ONE : id_lat;
    assign long_busy  = (lstate == L_BUSY);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                cnt[i] <= '0;
            end
            lstate <= L_IDLE;
        end else begin
            cnt[0] <= '0;
            // A fresh write to an entry wins over that entry's decrement.
            for (int i = 1; i < NREG; i++) begin
                if (issue && id_RegWrite && (id_rd_addr == 5'(i))) begin
                    cnt[i] <= eff_lat;
                end else if (cnt[i] != '0) begin
                    cnt[i] <= cnt[i] - LAT_ONE;
                end
            end
            case (lstate)
                L_IDLE: if (issue && id_long) lstate <= L_BUSY;
                L_BUSY: if (long_done && !(issue && id_long)) lstate <= L_IDLE;
                default: lstate <= L_IDLE;
            endcase
        end
    end

`ifdef HAZARD_STALL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= 32'h0;
        end else if (stall) begin
            stall_count <= stall_count + 32'h1;
        end
    end
`else
    assign stall_count = 32'h0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: load-use, ALU, long unit, flush, x0, reset, stall counter.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs1_addr;
    logic [4:0]  id_rs2_addr;
    logic        id_uses_rs1;
    logic        id_uses_rs2;
    logic        id_RegWrite;
    logic [4:0]  id_rd_addr;
    logic [2:0]  id_lat;
    logic        id_long;
    logic        long_done;
    logic        flush;
    logic        stall;
    logic        PC_write;
    logic        IFID_write;
    logic        ID_bubble;
    logic        long_busy;
    logic [31:0] stall_count;

    int n_checks = 0;
    int n_fail   = 0;

    hazard_scoreboard #(.LAT_W(3), .NREG(32)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_RegWrite(id_RegWrite), .id_rd_addr(id_rd_addr),
        .id_lat(id_lat), .id_long(id_long), .long_done(long_done),
        .flush(flush), .stall(stall), .PC_write(PC_write),
        .IFID_write(IFID_write), .ID_bubble(ID_bubble),
        .long_busy(long_busy), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    // Drives the ID-stage instruction; flush and long_done return to 0.
    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic rw,
                         input logic [4:0] rd, input logic [2:0] lat, input logic lng);
        id_valid    = v;
        id_rs1_addr = rs1;
        id_rs2_addr = rs2;
        id_uses_rs1 = u1;
        id_uses_rs2 = u2;
        id_RegWrite = rw;
        id_rd_addr  = rd;
        id_lat      = lat;
        id_long     = lng;
        flush       = 1'b0;
        long_done   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        settle();
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", stall); end
        n_checks++; if (PC_write !== 1'b1) begin n_fail++; $display("FAIL reset_pc_write got=%b exp=1", PC_write); end
        n_checks++; if (IFID_write !== 1'b1) begin n_fail++; $display("FAIL reset_ifid_write got=%b exp=1", IFID_write); end
        n_checks++; if (ID_bubble !== 1'b0) begin n_fail++; $display("FAIL reset_bubble got=%b exp=0", ID_bubble); end
        n_checks++; if (long_busy !== 1'b0) begin n_fail++; $display("FAIL reset_long_busy got=%b exp=0", long_busy); end
        n_checks++; if (stall_count !== 32'h0) begin n_fail++; $display("FAIL reset_stall_count got=%0d exp=0", stall_count); end
    endtask

    task automatic test_load_use();
        next_cycle(); drive(1, 0, 0, 0, 0, 1, 5, 2, 0); settle();
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL load_issue_stall got=%b exp=0", stall); end
        next_cycle(); drive(1, 5, 1, 1, 1, 1, 6, 1, 0); settle();
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL load_use_stall got=%b exp=1", stall); end
        n_checks++; if (ID_bubble !== 1'b1) begin n_fail++; $display("FAIL load_use_bubble got=%b exp=1", ID_bubble); end
        n_checks++; if (PC_write !== 1'b0) begin n_fail++; $display("FAIL load_use_pc_write got=%b exp=0", PC_write); end
        next_cycle(); settle();
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL load_use_release got=%b exp=0", stall); end
        n_checks++; if (ID_bubble !== 1'b0) begin n_fail++; $display("FAIL load_use_release_bubble got=%b exp=0", ID_bubble); end
        next_cycle(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_alu();
        next_cycle(); drive(1, 0, 0, 0, 0, 1, 7, 1, 0); settle();
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL alu_issue_stall got=%b exp=0", stall); end
        next_cycle(); drive(1, 7, 7, 1, 1, 1, 10, 0, 0); settle();
        n_checks++; if (ID_bubble !== 1'b0) begin n_fail++; $display("FAIL alu_reader_bubble got=%b exp=0", ID_bubble); end
        // x10 was written with lat 0, which behaves as lat 1
        next_cycle(); drive(1, 10, 0, 1, 0, 0, 0, 0, 0); settle();
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lat0_reader_stall got=%b exp=0", stall); end
        next_cycle(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_long();
        next_cycle(); drive(1, 0, 0, 0, 0, 1, 8, 5, 1); settle();
        n_checks++; if (long_busy !== 1'b0) begin n_fail++; $display("FAIL div_issue_busy got=%b exp=0", long_busy); end
        for (int k = 0; k < 4; k++) begin
            next_cycle(); drive(1, 8, 2, 1, 1, 1, 14, 1, 0); settle();
            n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL div_reader_stall%0d got=%b exp=1", k, stall); end
            n_checks++; if (long_busy !== 1'b1) begin n_fail++; $display("FAIL div_busy%0d got=%b exp=1", k, long_busy); end
        end
        next_cycle(); settle();
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL div_reader_release got=%b exp=0", stall); end
        next_cycle(); drive(1, 0, 0, 0, 0, 0, 0, 1, 1); settle();
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL struct_stall got=%b exp=1", stall); end
        n_checks++; if (ID_bubble !== 1'b1) begin n_fail++; $display("FAIL struct_bubble got=%b exp=1", ID_bubble); end
        next_cycle(); drive(1, 0, 0, 0, 0, 0, 0, 1, 1); long_done = 1'b1; settle();
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL struct_release got=%b exp=0", stall); end
        next_cycle(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0); settle();
        n_checks++; if (long_busy !== 1'b1) begin n_fail++; $display("FAIL back_to_back_busy got=%b exp=1", long_busy); end
        next_cycle(); long_done = 1'b1;
        next_cycle(); long_done = 1'b0; settle();
        n_checks++; if (long_busy !== 1'b0) begin n_fail++; $display("FAIL long_done_idle got=%b exp=0", long_busy); end
        next_cycle(); long_done = 1'b1;
        next_cycle(); long_done = 1'b0; settle();
        n_checks++; if (long_busy !== 1'b0) begin n_fail++; $display("FAIL done_in_idle got=%b exp=0", long_busy); end
    endtask

    task automatic test_flush();
        next_cycle(); drive(1, 0, 0, 0, 0, 1, 9, 2, 0);
        next_cycle(); drive(1, 9, 0, 1, 0, 1, 12, 3, 0); flush = 1'b1; settle();
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall got=%b exp=0", stall); end
        n_checks++; if (ID_bubble !== 1'b1) begin n_fail++; $display("FAIL flush_bubble got=%b exp=1", ID_bubble); end
        // x12 must not have been written by the flushed instruction
        next_cycle(); drive(1, 9, 12, 1, 1, 0, 0, 0, 0); settle();
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_no_write got=%b exp=0", stall); end
        next_cycle(); drive(1, 0, 0, 0, 0, 1, 13, 3, 0);
        next_cycle(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0); flush = 1'b1;
        next_cycle(); drive(1, 13, 0, 1, 0, 0, 0, 0, 0); settle();
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL flush_keeps_cnt got=%b exp=1", stall); end
        next_cycle(); settle();
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_cnt_release got=%b exp=0", stall); end
        next_cycle(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_x0();
        next_cycle(); drive(1, 0, 0, 0, 0, 1, 0, 3, 0);
        next_cycle(); drive(1, 0, 0, 1, 1, 0, 0, 0, 0); settle();
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL x0_reader_stall got=%b exp=0", stall); end
        next_cycle(); settle();
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL x0_reader_stall2 got=%b exp=0", stall); end
        next_cycle(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_mid();
        next_cycle(); drive(1, 0, 0, 0, 0, 1, 5, 3, 1);
        next_cycle(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0); rst = 1'b1;
        next_cycle(); rst = 1'b0; drive(1, 5, 0, 1, 0, 0, 0, 0, 0); settle();
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_mid_stall got=%b exp=0", stall); end
        n_checks++; if (long_busy !== 1'b0) begin n_fail++; $display("FAIL reset_mid_busy got=%b exp=0", long_busy); end
        next_cycle(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_perf();
        logic [31:0] exp_cnt;
`ifdef HAZARD_STALL_PERF_EN
        exp_cnt = 32'd5;
`else
        exp_cnt = 32'd0;
`endif
        do_reset();
        next_cycle(); drive(1, 0, 0, 0, 0, 1, 5, 2, 0);
        next_cycle(); drive(1, 5, 1, 1, 1, 1, 6, 1, 0);
        next_cycle();
        next_cycle(); drive(1, 0, 0, 0, 0, 1, 8, 5, 1);
        next_cycle(); drive(1, 8, 0, 1, 0, 1, 14, 1, 0);
        for (int k = 0; k < 4; k++) next_cycle();
        settle();
        n_checks++; if (stall_count !== exp_cnt) begin n_fail++; $display("FAIL perf_stall_count got=%0d exp=%0d", stall_count, exp_cnt); end
        next_cycle(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0); long_done = 1'b1;
        next_cycle(); long_done = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_alu();
        test_long();
        test_flush();
        test_x0();
        test_reset_mid();
        test_perf();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
